memory_port_arbiter: RTL and testbench

Sequencer and arbiter in front of the single-port, big-endian byte_addressable_memory. It shares the one memory port between the instruction-fetch requester (read-only, word) and the data requester (load/store, byte/half/word). It drives the memory's read/write strobes, handles the one-cycle read latency, and implements sub-word loads (with sign/zero extension) and sub-word stores (read-modify-write). Misaligned accesses are rejected without touching memory.

---
 rtl/memory_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_memory_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// Shares the single-port big-endian memory between instruction fetch and data access:
// arbitration, one-cycle read latency, sub-word load extension and read-modify-write stores.
module memory_port_arbiter #(
  parameter int FAIR = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wordIn,
  input  logic [31:0] mem_wordOut
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_e;

  typedef struct packed {
    logic        is_d;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lane;
    logic [31:0] wdata;
  } req_t;

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic        last_d_q, last_d_d;
  logic        i_ack_q, i_ack_d, d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic [31:0] mem_address_q, mem_address_d, mem_wordIn_q, mem_wordIn_d;

  // Winner of the current IDLE cycle and its decode
  logic        any_req, win_d, bad, word_store;
  logic [31:0] win_addr;
  always_comb begin
    any_req = i_req | d_req;
    if (i_req && d_req) win_d = (FAIR == 0) ? 1'b1 : !last_d_q;
    else                win_d = d_req;
    win_addr = win_d ? d_addr : i_addr;
    if (win_d)
      bad = (d_size == 2'b11) || (d_size == 2'b01 && d_addr[0]) ||
            (d_size == 2'b10 && d_addr[1:0] != 2'b00);
    else
      bad = (i_addr[1:0] != 2'b00);
    word_store = win_d && d_we && (d_size == 2'b10);
  end

  // Lane position within the big-endian word: byte k sits 8*(3-k) bits up
  logic [4:0]  sh;
  logic [31:0] mask, lane_val, load_val, merged;
  always_comb begin
    case (req_q.size)
      2'b00:   begin sh = {~req_q.lane, 3'b000};       mask = 32'h0000_00FF << sh; end
      2'b01:   begin sh = {~req_q.lane[1], 4'b0000};   mask = 32'h0000_FFFF << sh; end
      default: begin sh = 5'd0;                        mask = 32'hFFFF_FFFF;       end
    endcase
    lane_val = (mem_wordOut & mask) >> sh;
    case (req_q.size)
      2'b00:   load_val = req_q.uns ? {24'd0, lane_val[7:0]}  : {{24{lane_val[7]}}, lane_val[7:0]};
      2'b01:   load_val = req_q.uns ? {16'd0, lane_val[15:0]} : {{16{lane_val[15]}}, lane_val[15:0]};
      default: load_val = lane_val;
    endcase
    merged = (mem_wordOut & ~mask) | ((req_q.wdata << sh) & mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_q         <= '0;
      last_d_q      <= 1'b0;
      i_ack_q       <= 1'b0;
      d_ack_q       <= 1'b0;
      d_err_q       <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      mem_address_q <= '0;
      mem_wordIn_q  <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      last_d_q      <= last_d_d;
      i_ack_q       <= i_ack_d;
      d_ack_q       <= d_ack_d;
      d_err_q       <= d_err_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
      mem_address_q <= mem_address_d;
      mem_wordIn_q  <= mem_wordIn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = bad ? DONE : (word_store ? WR : RD);
      RD:      state_d = CAP;
      CAP:     state_d = req_q.we ? WR : DONE;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and acks are decided one state early so they leave the module registered
  always_comb begin
    req_d         = req_q;
    last_d_d      = last_d_q;
    i_ack_d       = 1'b0;
    d_ack_d       = 1'b0;
    d_err_d       = 1'b0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    mem_address_d = mem_address_q;
    mem_wordIn_d  = mem_wordIn_q;
    case (state_q)
      IDLE: if (any_req) begin
        req_d.is_d  = win_d;
        req_d.we    = win_d & d_we;
        req_d.size  = win_d ? d_size : 2'b10;
        req_d.uns   = d_unsigned;
        req_d.lane  = win_addr[1:0];
        req_d.wdata = d_wdata;
        last_d_d    = win_d;
        if (bad) begin
          i_ack_d = !win_d;
          d_ack_d = win_d;
          d_err_d = win_d;
        end else begin
          mem_address_d = {win_addr[31:2], 2'b00};
          if (word_store) begin
            mem_write_d  = 1'b1;
            mem_wordIn_d = d_wdata;
          end else begin
            mem_read_d = 1'b1;
          end
        end
      end
      CAP: if (req_q.we) begin
        mem_write_d  = 1'b1;
        mem_wordIn_d = merged;
      end else begin
        i_ack_d = !req_q.is_d;
        d_ack_d = req_q.is_d;
        if (req_q.is_d) d_rdata_d = load_val;
        else            i_rdata_d = mem_wordOut;
      end
      WR:      d_ack_d = 1'b1;
      default: ;
    endcase
  end

  assign i_ack       = i_ack_q;
  assign i_rdata     = i_rdata_q;
  assign d_ack       = d_ack_q;
  assign d_rdata     = d_rdata_q;
  assign d_err       = d_err_q;
  assign mem_address = mem_address_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_wordIn  = mem_wordIn_q;
endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: instance 0 built with FAIR=0, instance 1 with FAIR=1, each
// on its own big-endian byte memory; results compared against a byte-level reference model.
module tb_memory_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        i_req [2];
  logic [31:0] i_addr [2];
  logic        i_ack [2];
  logic [31:0] i_rdata [2];
  logic        d_req [2];
  logic        d_we [2];
  logic [1:0]  d_size [2];
  logic        d_unsigned [2];
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic        d_ack [2];
  logic [31:0] d_rdata [2];
  logic        d_err [2];
  logic [31:0] mem_address [2];
  logic        mem_read [2];
  logic        mem_write [2];
  logic [31:0] mem_wordIn [2];

  function automatic logic [7:0] init_byte(input int a);
    return 8'(a * 7 + 13);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0]  mem [1024];
    logic [31:0] rdo = 32'd0;
    logic [9:0]  wa;
    assign wa = {mem_address[g][9:2], 2'b00};

    memory_port_arbiter #(.FAIR(g)) u_dut (
      .clk(clk), .rst(rst),
      .i_req(i_req[g]), .i_addr(i_addr[g]), .i_ack(i_ack[g]), .i_rdata(i_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_size(d_size[g]), .d_unsigned(d_unsigned[g]),
      .d_addr(d_addr[g]), .d_wdata(d_wdata[g]), .d_ack(d_ack[g]), .d_rdata(d_rdata[g]),
      .d_err(d_err[g]), .mem_address(mem_address[g]), .mem_read(mem_read[g]),
      .mem_write(mem_write[g]), .mem_wordIn(mem_wordIn[g]), .mem_wordOut(rdo)
    );

    initial for (int a = 0; a < 1024; a++) mem[a] = init_byte(a);

    // Stand-in for the single-port memory: one-cycle read latency, word write
    always @(posedge clk) begin
      if (mem_read[g]) rdo <= {mem[wa], mem[wa + 10'd1], mem[wa + 10'd2], mem[wa + 10'd3]};
      if (mem_write[g]) begin
        mem[wa]         = mem_wordIn[g][31:24];
        mem[wa + 10'd1] = mem_wordIn[g][23:16];
        mem[wa + 10'd2] = mem_wordIn[g][15:8];
        mem[wa + 10'd3] = mem_wordIn[g][7:0];
      end
    end
  end

  // Reference model state
  logic [7:0]  ref_b [2][1024];
  logic [31:0] exp_irdata [2];
  logic [31:0] exp_drdata [2];
  bit          last_d [2];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input int k, input logic [31:0] addr, input int n, input bit uns);
    logic [31:0] v;
    int a;
    v = 32'd0;
    a = int'(addr & 32'd1023);
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_b[k][a + i]);
    if (!uns && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic chk_reset(input int k);
    chk("rst_i_ack", 32'(i_ack[k]), 32'd0);
    chk("rst_d_ack", 32'(d_ack[k]), 32'd0);
    chk("rst_d_err", 32'(d_err[k]), 32'd0);
    chk("rst_mem_read", 32'(mem_read[k]), 32'd0);
    chk("rst_mem_write", 32'(mem_write[k]), 32'd0);
    chk("rst_i_rdata", i_rdata[k], 32'd0);
    chk("rst_d_rdata", d_rdata[k], 32'd0);
    chk("rst_mem_address", mem_address[k], 32'd0);
    chk("rst_mem_wordIn", mem_wordIn[k], 32'd0);
  endtask

  // One complete transaction on instance k, checked for latency, strobes, data and err
  task automatic do_op(input int k, input bit is_d, input bit we, input logic [1:0] sz,
                       input bit uns, input logic [31:0] addr, input logic [31:0] wd);
    bit          bad_e;
    int          n, a, b, lat_e, rd_e, wr_e, lat, rd, wr;
    logic [7:0]  byt;
    logic [31:0] exp_w;
    n     = (is_d && sz != 2'b11) ? (1 << sz) : 4;
    bad_e = is_d ? (sz == 2'b11 || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00))
                 : (addr[1:0] != 2'b00);
    lat_e = bad_e ? 1 : (is_d && we) ? ((sz == 2'b10) ? 2 : 4) : 3;
    rd_e  = (bad_e || (is_d && we && sz == 2'b10)) ? 0 : 1;
    wr_e  = (!bad_e && is_d && we) ? 1 : 0;
    a     = int'(addr & 32'd1023);
    exp_w = 32'd0;
    for (int i = 0; i < 4; i++) begin
      b   = (a & ~3) + i;
      byt = ref_b[k][b];
      if (b >= a && b < a + n) byt = 8'(wd >> (8 * (a + n - 1 - b)));
      exp_w = (exp_w << 8) | 32'(byt);
    end
    if (!bad_e && !(is_d && we)) begin
      if (is_d) exp_drdata[k] = ref_load(k, addr, n, uns);
      else      exp_irdata[k] = ref_load(k, addr, 4, 1'b1);
    end

    @(negedge clk);
    if (is_d) begin
      d_req[k] = 1'b1; d_we[k] = we; d_size[k] = sz; d_unsigned[k] = uns;
      d_addr[k] = addr; d_wdata[k] = wd;
    end else begin
      i_req[k] = 1'b1; i_addr[k] = addr;
    end
    lat = 0; rd = 0; wr = 0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(posedge clk); #1;
      chk("strobe_excl", 32'(mem_read[k] & mem_write[k]), 32'd0);
      if (mem_read[k]) begin
        rd++;
        chk("rd_addr", mem_address[k], addr & ~32'd3);
      end
      if (mem_write[k]) begin
        wr++;
        chk("wr_addr", mem_address[k], addr & ~32'd3);
        chk("wr_data", mem_wordIn[k], exp_w);
      end
      chk("other_ack", 32'(is_d ? i_ack[k] : d_ack[k]), 32'd0);
      if (is_d ? d_ack[k] : i_ack[k]) lat = c;
    end
    i_req[k] = 1'b0;
    d_req[k] = 1'b0;
    chk("latency", 32'(lat), 32'(lat_e));
    chk("reads", 32'(rd), 32'(rd_e));
    chk("writes", 32'(wr), 32'(wr_e));
    if (is_d) chk("d_err", 32'(d_err[k]), 32'(bad_e));
    chk("d_rdata", d_rdata[k], exp_drdata[k]);
    chk("i_rdata", i_rdata[k], exp_irdata[k]);
    @(posedge clk); #1;
    chk("ack_pulse", 32'(is_d ? d_ack[k] : i_ack[k]), 32'd0);
    if (!bad_e && is_d && we)
      for (int i = 0; i < n; i++) ref_b[k][a + i] = 8'(wd >> (8 * (n - 1 - i)));
    last_d[k] = is_d;
  endtask

  // Fetch and word load raised on the same edge
  task automatic do_tie(input int k, input logic [31:0] ia, input logic [31:0] da);
    bit          win_d;
    int          ci, cd;
    logic [31:0] ei, ed;
    win_d = (k == 0) ? 1'b1 : !last_d[k];  // instance index equals its FAIR setting
    ei = ref_load(k, ia, 4, 1'b1);
    ed = ref_load(k, da, 4, 1'b1);
    @(negedge clk);
    i_req[k] = 1'b1; i_addr[k] = ia;
    d_req[k] = 1'b1; d_we[k] = 1'b0; d_size[k] = 2'b10; d_unsigned[k] = 1'b0; d_addr[k] = da;
    ci = 0; cd = 0;
    for (int c = 1; c <= 20 && (ci == 0 || cd == 0); c++) begin
      @(posedge clk); #1;
      if (i_ack[k]) begin ci = c; i_req[k] = 1'b0; chk("tie_i_rdata", i_rdata[k], ei); end
      if (d_ack[k]) begin cd = c; d_req[k] = 1'b0; chk("tie_d_rdata", d_rdata[k], ed); end
    end
    i_req[k] = 1'b0;
    d_req[k] = 1'b0;
    chk("tie_i_lat", 32'(ci), win_d ? 32'd7 : 32'd3);
    chk("tie_d_lat", 32'(cd), win_d ? 32'd3 : 32'd7);
    exp_irdata[k] = ei;
    exp_drdata[k] = ed;
    last_d[k]     = !win_d;
    @(posedge clk);
  endtask

  // Byte store at 403 on instance 0, reset sampled at edge rst_at after the request edge
  task automatic do_rst(input int rst_at, input logic [7:0] val);
    @(negedge clk);
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_size[0] = 2'b00; d_unsigned[0] = 1'b0;
    d_addr[0] = 32'd403; d_wdata[0] = {24'd0, val};
    repeat (rst_at) @(posedge clk);
    #1 chk("pre_rst_write", 32'(mem_write[0]), 32'(rst_at == 3));
    @(negedge clk);
    rst = 1'b1;
    d_req[0] = 1'b0;
    @(posedge clk); #1;
    chk_reset(0);
    chk_reset(1);
    @(negedge clk);
    rst = 1'b0;
    // A strobe already on the port at the reset edge still lands in memory
    if (rst_at == 3) ref_b[0][403] = val;
    for (int k = 0; k < 2; k++) begin
      exp_irdata[k] = 32'd0; exp_drdata[k] = 32'd0; last_d[k] = 1'b0;
    end
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_ack", 32'(d_ack[0]), 32'd0);
      chk("post_rst_strobe", 32'(mem_read[0] | mem_write[0]), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0; i_addr[k] = 32'd0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_size[k] = 2'b00; d_unsigned[k] = 1'b0; d_addr[k] = 32'd0; d_wdata[k] = 32'd0;
      exp_irdata[k] = 32'd0; exp_drdata[k] = 32'd0; last_d[k] = 1'b0;
      for (int a = 0; a < 1024; a++) ref_b[k][a] = init_byte(a);
    end
    repeat (2) @(posedge clk);
    #1 chk_reset(0);
    chk_reset(1);
    @(negedge clk);
    rst = 1'b0;

    do_op(0, 1, 1, 2'b10, 0, 32'd400, 32'hAABB_CCDD);
    do_op(0, 1, 0, 2'b10, 0, 32'd400, 32'd0);
    do_op(0, 1, 0, 2'b00, 0, 32'd401, 32'd0);
    do_op(0, 1, 0, 2'b00, 1, 32'd401, 32'd0);
    do_op(0, 1, 0, 2'b01, 0, 32'd402, 32'd0);
    do_op(0, 1, 0, 2'b01, 1, 32'd400, 32'd0);
    do_op(0, 1, 1, 2'b00, 0, 32'd403, 32'h0000_0077);
    do_op(0, 1, 1, 2'b01, 0, 32'd400, 32'h0000_1234);
    do_op(0, 1, 0, 2'b10, 0, 32'd400, 32'd0);
    do_op(0, 1, 0, 2'b01, 0, 32'd401, 32'd0);
    do_op(0, 1, 0, 2'b10, 0, 32'd402, 32'd0);
    do_op(0, 1, 0, 2'b11, 0, 32'd400, 32'd0);
    do_op(0, 0, 0, 2'b10, 0, 32'd400, 32'd0);
    do_op(0, 0, 0, 2'b10, 0, 32'd402, 32'd0);
    do_tie(0, 32'd400, 32'd404);

    do_tie(1, 32'd400, 32'd404);
    do_op(1, 1, 0, 2'b10, 0, 32'd408, 32'd0);
    do_tie(1, 32'd412, 32'd416);
    do_op(1, 1, 0, 2'b00, 1, 32'd420, 32'd0);

    do_rst(2, 8'h5A);
    do_op(0, 1, 0, 2'b10, 0, 32'd400, 32'd0);
    do_tie(1, 32'd400, 32'd404);
    do_rst(3, 8'hC3);
    do_op(0, 1, 0, 2'b10, 0, 32'd400, 32'd0);

    for (int t = 0; t < 120; t++) begin
      int          k, r, n;
      logic [1:0]  sz;
      logic [31:0] addr, wd;
      k    = t & 1;
      r    = int'($urandom_range(0, 9));
      addr = 32'($urandom_range(0, 1023));
      wd   = $urandom;
      if (r == 9 && k == 1) begin
        do_tie(1, addr & ~32'd3, 32'($urandom_range(0, 255)) << 2);
      end else if (r < 2) begin
        if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
        do_op(k, 0, 0, 2'b10, 0, addr, 32'd0);
      end else begin
        sz = 2'($urandom_range(0, 2));
        if ($urandom_range(0, 9) == 0) sz = 2'b11;
        n = (sz == 2'b11) ? 1 : (1 << sz);
        if ($urandom_range(0, 3) != 0) addr = addr & ~32'(n - 1);
        do_op(k, 1, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, wd);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
